// File: rtl/instr_fetch.sv
// RISC-V fetch stage: PC, single-outstanding imem req/gnt/rvalid handshake and IF/ID register.
// Optional IFETCH_MISALIGN_CHK_EN adds misalign_err and a HALT state for misaligned redirects.
module instr_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        id_ready,
    output logic        id_valid,
    output logic [31:0] id_instruction,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc_plus4
`ifdef IFETCH_MISALIGN_CHK_EN
    ,
    output logic        misalign_err
`endif
);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_REQ  = 3'd1;
    localparam logic [2:0] ST_WAIT = 3'd2;
    localparam logic [2:0] ST_HOLD = 3'd3;
`ifdef IFETCH_MISALIGN_CHK_EN
    localparam logic [2:0] ST_HALT = 3'd4;
`endif

    function automatic logic [31:0] pc_inc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

    logic [2:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] req_pc_q, req_pc_d;
    logic        kill_q, kill_d;
    logic        hold_valid_q, hold_valid_d;
    logic [31:0] hold_instr_q, hold_instr_d;
    logic        id_valid_q, id_valid_d;
    logic [31:0] id_instr_q, id_instr_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic [31:0] id_pc4_q, id_pc4_d;
    logic        imem_req_q, imem_req_d;
`ifdef IFETCH_MISALIGN_CHK_EN
    logic        merr_q, merr_d;
    logic        halt_take_s;
`endif

    logic        slot_free_s;
    logic        redir_take_s;
    logic [2:0]  redir_state_s;
    logic        redir_kill_s;

    assign slot_free_s = !id_valid_q || id_ready;

`ifdef IFETCH_MISALIGN_CHK_EN
    assign redir_take_s = redirect_valid && (state_q != ST_HALT) && (redirect_pc[1:0] == 2'b00);
    assign halt_take_s  = redirect_valid && (state_q != ST_HALT) && (redirect_pc[1:0] != 2'b00);
`else
    assign redir_take_s = redirect_valid;
`endif

    // Redirect transition: an accepted-but-unanswered request leaves one response to discard.
    always_comb begin
        redir_state_s = ST_REQ;
        redir_kill_s  = 1'b0;
        case (state_q)
            ST_WAIT: begin
                if (imem_rvalid) begin
                    redir_state_s = ST_REQ;
                    redir_kill_s  = 1'b0;
                end else begin
                    redir_state_s = ST_WAIT;
                    redir_kill_s  = 1'b1;
                end
            end
            ST_REQ: begin
                if (imem_gnt) begin
                    redir_state_s = ST_WAIT;
                    redir_kill_s  = 1'b1;
                end else begin
                    redir_state_s = ST_REQ;
                    redir_kill_s  = 1'b0;
                end
            end
            default: begin
                redir_state_s = ST_REQ;
                redir_kill_s  = 1'b0;
            end
        endcase
    end

    // Next-state logic for the fetch FSM, hold buffer and IF/ID register.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        req_pc_d     = req_pc_q;
        kill_d       = kill_q;
        hold_valid_d = hold_valid_q;
        hold_instr_d = hold_instr_q;
        id_valid_d   = id_valid_q;
        id_instr_d   = id_instr_q;
        id_pc_d      = id_pc_q;
        id_pc4_d     = id_pc4_q;
`ifdef IFETCH_MISALIGN_CHK_EN
        merr_d       = merr_q;
`endif
        if (redir_take_s) begin
            id_valid_d   = 1'b0;
            id_instr_d   = NOP_INSTR;
            hold_valid_d = 1'b0;
            pc_d         = redirect_pc & 32'hFFFF_FFFC;
            state_d      = redir_state_s;
            kill_d       = redir_kill_s;
`ifdef IFETCH_MISALIGN_CHK_EN
        end else if (halt_take_s) begin
            id_valid_d   = 1'b0;
            id_instr_d   = NOP_INSTR;
            hold_valid_d = 1'b0;
            kill_d       = 1'b0;
            merr_d       = 1'b1;
            state_d      = ST_HALT;
`endif
        end else begin
            // Consumption empties the slot unless a new word is loaded below.
            if (id_valid_q && id_ready) begin
                id_valid_d = 1'b0;
                id_instr_d = NOP_INSTR;
            end else begin
                id_valid_d = id_valid_q;
                id_instr_d = id_instr_q;
            end

            case (state_q)
                ST_IDLE: state_d = ST_REQ;
                ST_REQ: begin
                    if (imem_gnt) begin
                        req_pc_d = pc_q;
                        state_d  = ST_WAIT;
                    end else begin
                        state_d  = ST_REQ;
                    end
                end
                ST_WAIT: begin
                    if (imem_rvalid) begin
                        if (kill_q) begin
                            kill_d  = 1'b0;
                            state_d = ST_REQ;
                        end else if (slot_free_s) begin
                            id_valid_d = 1'b1;
                            id_instr_d = imem_rdata;
                            id_pc_d    = req_pc_q;
                            id_pc4_d   = pc_inc(req_pc_q);
                            pc_d       = pc_inc(req_pc_q);
                            state_d    = ST_REQ;
                        end else begin
                            hold_valid_d = 1'b1;
                            hold_instr_d = imem_rdata;
                            pc_d         = pc_inc(req_pc_q);
                            state_d      = ST_HOLD;
                        end
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
                ST_HOLD: begin
                    if (id_ready && hold_valid_q) begin
                        id_valid_d   = 1'b1;
                        id_instr_d   = hold_instr_q;
                        id_pc_d      = req_pc_q;
                        id_pc4_d     = pc_inc(req_pc_q);
                        hold_valid_d = 1'b0;
                        state_d      = ST_REQ;
                    end else begin
                        state_d = ST_HOLD;
                    end
                end
`ifdef IFETCH_MISALIGN_CHK_EN
                ST_HALT: state_d = ST_HALT;
`endif
                default: state_d = ST_IDLE;
            endcase
        end

        imem_req_d = (state_d == ST_REQ);
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            pc_q         <= RESET_PC;
            req_pc_q     <= RESET_PC;
            kill_q       <= 1'b0;
            hold_valid_q <= 1'b0;
            hold_instr_q <= NOP_INSTR;
            id_valid_q   <= 1'b0;
            id_instr_q   <= NOP_INSTR;
            id_pc_q      <= RESET_PC;
            id_pc4_q     <= RESET_PC + 32'd4;
            imem_req_q   <= 1'b0;
`ifdef IFETCH_MISALIGN_CHK_EN
            merr_q       <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            req_pc_q     <= req_pc_d;
            kill_q       <= kill_d;
            hold_valid_q <= hold_valid_d;
            hold_instr_q <= hold_instr_d;
            id_valid_q   <= id_valid_d;
            id_instr_q   <= id_instr_d;
            id_pc_q      <= id_pc_d;
            id_pc4_q     <= id_pc4_d;
            imem_req_q   <= imem_req_d;
`ifdef IFETCH_MISALIGN_CHK_EN
            merr_q       <= merr_d;
`endif
        end
    end

    assign imem_req       = imem_req_q;
    assign imem_addr      = pc_q;
    assign id_valid       = id_valid_q;
    assign id_instruction = id_instr_q;
    assign id_pc          = id_pc_q;
    assign id_pc_plus4    = id_pc4_q;
`ifdef IFETCH_MISALIGN_CHK_EN
    assign misalign_err   = merr_q;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed vector table, hand-written corner sequences, then
// randomized memory/decode/redirect traffic checked against a fetch-stream scoreboard.
module tb_instr_fetch;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] W0  = 32'h0031_00B3;
    localparam logic [31:0] W1  = 32'h4062_8233;
    localparam logic [31:0] W2  = 32'h00A1_8093;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_ready;
    logic        id_valid;
    logic [31:0] id_instruction;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;
`ifdef IFETCH_MISALIGN_CHK_EN
    logic        misalign_err;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    instr_fetch dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_ready       (id_ready),
        .id_valid       (id_valid),
        .id_instruction (id_instruction),
        .id_pc          (id_pc),
        .id_pc_plus4    (id_pc_plus4)
`ifdef IFETCH_MISALIGN_CHK_EN
        ,
        .misalign_err   (misalign_err)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        rst;
        logic        gnt;
        logic        rv;
        logic [31:0] rdata;
        logic        rdy;
        logic        redir;
        logic [31:0] rpc;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_v;
        logic [31:0] e_instr;
        logic [31:0] e_pc;
    } vec_t;

    vec_t vq[$];

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic g, input logic v, input logic [31:0] d,
                       input logic rd, input logic rr, input logic [31:0] rp,
                       input logic er, input logic [31:0] ea, input logic ev,
                       input logic [31:0] ei, input logic [31:0] ep);
        vec_t t;
        t.rst = r; t.gnt = g; t.rv = v; t.rdata = d; t.rdy = rd; t.redir = rr; t.rpc = rp;
        t.e_req = er; t.e_addr = ea; t.e_v = ev; t.e_instr = ei; t.e_pc = ep;
        vq.push_back(t);
    endtask

    task automatic drive(input logic r, input logic g, input logic v, input logic [31:0] d,
                         input logic rd, input logic rr, input logic [31:0] rp);
        @(negedge clk);
        rst_n = r; imem_gnt = g; imem_rvalid = v; imem_rdata = d;
        id_ready = rd; redirect_valid = rr; redirect_pc = rp;
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic er, input logic [31:0] ea,
                             input logic ev, input logic [31:0] ei, input logic [31:0] ep);
        chk1 ({tag, "_req"},   imem_req, er);
        chk32({tag, "_addr"},  imem_addr, ea);
        chk1 ({tag, "_valid"}, id_valid, ev);
        chk32({tag, "_instr"}, id_instruction, ei);
        chk32({tag, "_pc"},    id_pc, ep);
        chk32({tag, "_pc4"},   id_pc_plus4, ep + 32'd4);
    endtask

    function automatic logic [31:0] memf(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    initial begin
        logic        pend;
        int          cnt;
        logic [31:0] paddr;
        logic [31:0] exp_pc;
        int          consumed;
        logic        g, v, rd, rr;
        logic [31:0] d, rp;

        rst_n = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'd0;
        id_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0;

        //   rst  gnt  rv   rdata          rdy  rdir rpc             req  addr           v    instr          pc
        add(1'b0,1'b0,1'b0,32'd0,         1'b0,1'b0,32'd0,          1'b0,32'h0,        1'b0,NOP,          32'h0);
        add(1'b1,1'b0,1'b0,32'd0,         1'b0,1'b0,32'd0,          1'b1,32'h0,        1'b0,NOP,          32'h0);
        add(1'b1,1'b1,1'b0,32'd0,         1'b0,1'b0,32'd0,          1'b0,32'h0,        1'b0,NOP,          32'h0);
        add(1'b1,1'b0,1'b1,W0,            1'b1,1'b0,32'd0,          1'b1,32'h4,        1'b1,W0,           32'h0);
        add(1'b1,1'b1,1'b0,32'd0,         1'b0,1'b0,32'd0,          1'b0,32'h4,        1'b1,W0,           32'h0);
        add(1'b1,1'b0,1'b1,W1,            1'b0,1'b0,32'd0,          1'b0,32'h8,        1'b1,W0,           32'h0);
        add(1'b1,1'b0,1'b0,32'd0,         1'b0,1'b0,32'd0,          1'b0,32'h8,        1'b1,W0,           32'h0);
        add(1'b1,1'b0,1'b0,32'd0,         1'b0,1'b0,32'd0,          1'b0,32'h8,        1'b1,W0,           32'h0);
        add(1'b1,1'b0,1'b0,32'd0,         1'b0,1'b0,32'd0,          1'b0,32'h8,        1'b1,W0,           32'h0);
        add(1'b1,1'b0,1'b0,32'd0,         1'b1,1'b0,32'd0,          1'b1,32'h8,        1'b1,W1,           32'h4);
        add(1'b1,1'b1,1'b0,32'd0,         1'b1,1'b0,32'd0,          1'b0,32'h8,        1'b0,NOP,          32'h4);
        add(1'b1,1'b0,1'b1,W2,            1'b1,1'b0,32'd0,          1'b1,32'hC,        1'b1,W2,           32'h8);
        add(1'b1,1'b1,1'b0,32'd0,         1'b1,1'b0,32'd0,          1'b0,32'hC,        1'b0,NOP,          32'h8);
        add(1'b1,1'b0,1'b0,32'd0,         1'b0,1'b1,32'h100,        1'b0,32'h100,      1'b0,NOP,          32'h8);
        add(1'b1,1'b0,1'b1,32'hDEADBEEF,  1'b1,1'b0,32'd0,          1'b1,32'h100,      1'b0,NOP,          32'h8);
        add(1'b1,1'b1,1'b0,32'd0,         1'b1,1'b0,32'd0,          1'b0,32'h100,      1'b0,NOP,          32'h8);
        add(1'b1,1'b0,1'b1,32'h11111113,  1'b1,1'b0,32'd0,          1'b1,32'h104,      1'b1,32'h11111113, 32'h100);
        add(1'b1,1'b1,1'b0,32'd0,         1'b1,1'b0,32'd0,          1'b0,32'h104,      1'b0,NOP,          32'h100);
        add(1'b1,1'b0,1'b1,32'hBAD00001,  1'b1,1'b1,32'h200,        1'b1,32'h200,      1'b0,NOP,          32'h100);
        add(1'b1,1'b1,1'b0,32'd0,         1'b1,1'b1,32'h200,        1'b0,32'h200,      1'b0,NOP,          32'h100);
        add(1'b1,1'b0,1'b1,32'hBAD00002,  1'b1,1'b0,32'd0,          1'b1,32'h200,      1'b0,NOP,          32'h100);
        add(1'b1,1'b1,1'b0,32'd0,         1'b1,1'b0,32'd0,          1'b0,32'h200,      1'b0,NOP,          32'h100);
        add(1'b1,1'b0,1'b1,32'h22222213,  1'b1,1'b0,32'd0,          1'b1,32'h204,      1'b1,32'h22222213, 32'h200);
        add(1'b1,1'b0,1'b0,32'd0,         1'b1,1'b0,32'd0,          1'b1,32'h204,      1'b0,NOP,          32'h200);
        add(1'b1,1'b0,1'b0,32'd0,         1'b1,1'b0,32'd0,          1'b1,32'h204,      1'b0,NOP,          32'h200);
        add(1'b1,1'b0,1'b0,32'd0,         1'b1,1'b0,32'd0,          1'b1,32'h204,      1'b0,NOP,          32'h200);
        add(1'b1,1'b0,1'b0,32'd0,         1'b1,1'b1,32'h40,         1'b1,32'h40,       1'b0,NOP,          32'h200);
        add(1'b1,1'b1,1'b0,32'd0,         1'b1,1'b0,32'd0,          1'b0,32'h40,       1'b0,NOP,          32'h200);
        add(1'b1,1'b0,1'b1,32'h33333313,  1'b1,1'b0,32'd0,          1'b1,32'h44,       1'b1,32'h33333313, 32'h40);
        add(1'b1,1'b1,1'b0,32'd0,         1'b1,1'b0,32'd0,          1'b0,32'h44,       1'b0,NOP,          32'h40);
        add(1'b0,1'b0,1'b0,32'd0,         1'b0,1'b0,32'd0,          1'b0,32'h0,        1'b0,NOP,          32'h0);
        add(1'b1,1'b0,1'b1,32'hBAD00003,  1'b0,1'b0,32'd0,          1'b1,32'h0,        1'b0,NOP,          32'h0);
        add(1'b1,1'b1,1'b0,32'd0,         1'b0,1'b0,32'd0,          1'b0,32'h0,        1'b0,NOP,          32'h0);
        add(1'b1,1'b0,1'b1,W0,            1'b1,1'b0,32'd0,          1'b1,32'h4,        1'b1,W0,           32'h0);
        add(1'b1,1'b0,1'b0,32'd0,         1'b1,1'b1,32'hFFFFFFFC,   1'b1,32'hFFFFFFFC, 1'b0,NOP,          32'h0);
        add(1'b1,1'b1,1'b0,32'd0,         1'b1,1'b0,32'd0,          1'b0,32'hFFFFFFFC, 1'b0,NOP,          32'h0);
        add(1'b1,1'b0,1'b1,32'h44444413,  1'b1,1'b0,32'd0,          1'b1,32'h0,        1'b1,32'h44444413, 32'hFFFFFFFC);
`ifdef IFETCH_MISALIGN_CHK_EN
        add(1'b1,1'b0,1'b0,32'd0,         1'b0,1'b1,32'h102,        1'b0,32'h0,        1'b0,NOP,          32'hFFFFFFFC);
        add(1'b1,1'b0,1'b0,32'd0,         1'b0,1'b1,32'h300,        1'b0,32'h0,        1'b0,NOP,          32'hFFFFFFFC);
        add(1'b1,1'b1,1'b0,32'd0,         1'b1,1'b0,32'd0,          1'b0,32'h0,        1'b0,NOP,          32'hFFFFFFFC);
`else
        add(1'b1,1'b0,1'b0,32'd0,         1'b0,1'b1,32'h102,        1'b1,32'h100,      1'b0,NOP,          32'hFFFFFFFC);
        add(1'b1,1'b0,1'b0,32'd0,         1'b0,1'b1,32'h300,        1'b1,32'h300,      1'b0,NOP,          32'hFFFFFFFC);
        add(1'b1,1'b0,1'b0,32'd0,         1'b1,1'b0,32'd0,          1'b1,32'h300,      1'b0,NOP,          32'hFFFFFFFC);
`endif

        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].rst, vq[i].gnt, vq[i].rv, vq[i].rdata, vq[i].rdy, vq[i].redir, vq[i].rpc);
            check_out($sformatf("vec%0d", i), vq[i].e_req, vq[i].e_addr, vq[i].e_v,
                      vq[i].e_instr, vq[i].e_pc);
`ifdef IFETCH_MISALIGN_CHK_EN
            chk1($sformatf("vec%0d_merr", i), misalign_err, (i >= 37));
`endif
        end

        // Back-to-back redirects: the second replaces the first, only one stale response dropped.
        drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        check_out("b2b_rst", 1'b0, 32'h0, 1'b0, NOP, 32'h0);
`ifdef IFETCH_MISALIGN_CHK_EN
        chk1("b2b_merr_cleared", misalign_err, 1'b0);
`endif
        drive(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        check_out("b2b_req", 1'b1, 32'h0, 1'b0, NOP, 32'h0);
        drive(1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 1'b1, 32'h500);
        check_out("b2b_r1", 1'b0, 32'h500, 1'b0, NOP, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 32'h600);
        check_out("b2b_r2", 1'b0, 32'h600, 1'b0, NOP, 32'h0);
        drive(1'b1, 1'b0, 1'b1, 32'hBAD00004, 1'b1, 1'b0, 32'd0);
        check_out("b2b_drop", 1'b1, 32'h600, 1'b0, NOP, 32'h0);
        drive(1'b1, 1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
        check_out("b2b_gnt", 1'b0, 32'h600, 1'b0, NOP, 32'h0);
        drive(1'b1, 1'b0, 1'b1, 32'h66666613, 1'b1, 1'b0, 32'd0);
        check_out("b2b_load", 1'b1, 32'h604, 1'b1, 32'h66666613, 32'h600);

        // Randomized traffic: variable-latency memory, random backpressure and redirects.
        drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        pend = 1'b0; cnt = 0; paddr = 32'd0; exp_pc = 32'h0; consumed = 0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (!id_valid) chk32("rnd_nop_when_invalid", id_instruction, NOP);
            chk32("rnd_pc_plus4", id_pc_plus4, id_pc + 32'd4);
            if (pend) chk1("rnd_one_outstanding", imem_req, 1'b0);
            if (imem_req) chk32("rnd_addr_aligned", {30'd0, imem_addr[1:0]}, 32'd0);

            rd = ($urandom_range(0, 9) < 6);
            rr = ($urandom_range(0, 99) < 6);
            if ($urandom_range(0, 7) == 0) rp = 32'hFFFF_FFF0 | ($urandom_range(0, 3) << 2);
            else rp = $urandom_range(0, 4095);
`ifdef IFETCH_MISALIGN_CHK_EN
            rp[1:0] = 2'b00;
`endif
            v = 1'b0;
            d = $urandom;
            if (pend) begin
                cnt--;
                if (cnt == 0) begin
                    v = 1'b1;
                    d = memf(paddr);
                    pend = 1'b0;
                end
            end
            g = 1'b0;
            if (imem_req && !pend && ($urandom_range(0, 9) < 7)) begin
                g = 1'b1;
                pend = 1'b1;
                cnt = $urandom_range(1, 3);
                paddr = imem_addr;
            end

            if (rr) begin
                exp_pc = rp & 32'hFFFF_FFFC;
            end else if (id_valid && rd) begin
                chk32("rnd_id_pc", id_pc, exp_pc);
                chk32("rnd_id_instr", id_instruction, memf(exp_pc));
                exp_pc = exp_pc + 32'd4;
                consumed++;
            end

            imem_gnt = g; imem_rvalid = v; imem_rdata = d;
            id_ready = rd; redirect_valid = rr; redirect_pc = rp;
        end
        chk1("rnd_progress", (consumed >= 100), 1'b1);
`ifdef IFETCH_MISALIGN_CHK_EN
        chk1("rnd_merr_clear", misalign_err, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Fetch stage of the RISC-V core, directly upstream of instr_decoder.
- Holds the PC and issues word requests to instruction memory over a req/gnt + rvalid handshake, with at most one request outstanding.
- Drives the IF/ID pipeline register whose id_instruction output feeds instr_decoder.instruction.
- Takes id_ready backpressure from decode and redirect_valid/redirect_pc from branch/jump resolution, which flushes the register.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; first fetch address.
NOP_INSTR, 32'h0000_0013, instruction driven when id_valid=0 (addi x0,x0,0).

Ports:
clk  in  1  core clock, all state updates on posedge
rst_n  in  1  synchronous active-low reset
imem_req  out  1  fetch request
imem_addr  out  32  word-aligned fetch address
imem_gnt  in  1  request accepted this cycle
imem_rvalid  in  1  response data valid
imem_rdata  in  32  fetched instruction
redirect_valid  in  1  one-cycle branch/jump redirect
redirect_pc  in  32  redirect target
id_ready  in  1  decode consumes IF/ID contents this cycle
id_valid  out  1  IF/ID register holds a live instruction
id_instruction  out  32  to instr_decoder.instruction
id_pc  out  32  PC of id_instruction
id_pc_plus4  out  32  id_pc + 4, for JAL/JALR link

Behaviour:
- Reset (rst_n=0 at posedge): state=IDLE, pc=RESET_PC, kill=0, hold_valid=0, id_valid=0, id_instruction=NOP_INSTR, id_pc=RESET_PC, id_pc_plus4=RESET_PC+4, imem_req=0. Reset mid-transaction abandons the outstanding request; a late imem_rvalid in IDLE is ignored.
- States: IDLE, REQ, WAIT, HOLD.
- IDLE: imem_req=0; next cycle goes to REQ.
- REQ: imem_req=1, imem_addr=pc. If imem_gnt=1: latch req_pc=pc, go to WAIT. imem_addr changes while imem_req=1 only on redirect.
- WAIT: imem_req=0. Wait for imem_rvalid.
  - If kill=1: discard the data, clear kill, go to REQ.
  - Else if the slot is free (!id_valid || id_ready): load IF/ID with {1, imem_rdata, req_pc, req_pc+4}, set pc=req_pc+4, go to REQ.
  - Else: capture the response in the hold buffer, set pc=req_pc+4, go to HOLD.
- HOLD: imem_req=0. When id_ready=1, move the hold buffer into IF/ID and go to REQ.
- Latency: imem_req to id_valid = grant cycle + response cycle + 1. With single-cycle memory (gnt same cycle, rvalid next cycle), the first id_valid rises 3 cycles after reset release. Steady-state throughput is 1 instruction per 2 cycles (no pipelined requests).
- id_ready=1 with no new data loaded: id_valid=0 and id_instruction=NOP_INSTR next cycle.
- id_valid=0 always implies id_instruction=NOP_INSTR.
- Redirect has highest priority. Same edge, in any state:
  - id_valid=0, id_instruction=NOP_INSTR, hold_valid=0.
  - pc=redirect_pc with bits [1:0] forced to 0.
  - From WAIT without imem_rvalid: kill=1, stay in WAIT.
  - From WAIT with imem_rvalid the same cycle: data discarded, go to REQ.
  - From REQ with imem_gnt the same cycle: go to WAIT with kill=1.
  - From REQ without imem_gnt: stay in REQ; the next cycle presents the new address.
  - From HOLD or IDLE: go to REQ.
- Back-to-back redirects: the last one wins. kill never exceeds one pending discard.
- PC arithmetic is 32-bit modulo. 32'hFFFF_FFFC + 4 wraps to 32'h0000_0000.

Optional Feature:
- Macro IFETCH_MISALIGN_CHK_EN.
- Defined:
  - Adds output port misalign_err (1 bit, reset 0).
  - A redirect with redirect_pc[1:0]!=0 sets misalign_err sticky, flushes IF/ID, and enters a HALT state: imem_req=0, id_valid=0, redirect ignored.
  - Only reset exits HALT.
- Undefined: no port and no HALT state; bits [1:0] are silently cleared.

Test Plan:
- Reset, single-cycle memory returning 32'h003100B3, 32'h40628233, 32'h00A18093 at 0x0/0x4/0x8, id_ready=1 -> imem_addr 0x0,0x4,0x8 in order; id_instruction shows the three words with id_pc 0x0/0x4/0x8 and id_pc_plus4 0x4/0x8/0xC; first id_valid 3 cycles after rst_n rises.
- id_ready=0 for 5 cycles after the first instruction -> id_instruction holds 32'h003100B3; the second response parks in HOLD; no imem_req during HOLD; on id_ready=1, 32'h40628233 appears next cycle; no word lost or duplicated.
- redirect_valid with redirect_pc=0x100 while in WAIT -> id_valid=0, NOP_INSTR next cycle; the in-flight response is dropped; the next imem_addr is 0x100 and the next id_pc is 0x100.
- redirect_valid coincident with imem_rvalid, and separately with imem_gnt, target 0x200 -> neither stale word reaches IF/ID; the next delivered id_pc is 0x200.
- imem_gnt held low 4 cycles -> imem_req stays 1 with a stable imem_addr; redirect to 0x40 during the stall changes imem_addr to 0x40 the next cycle.
- rst_n low for one cycle in WAIT, and (with IFETCH_MISALIGN_CHK_EN) redirect to 0x102 -> reset returns all outputs to reset values, the fetch restarts at RESET_PC, and the late rvalid is ignored; the misaligned redirect gives misalign_err=1, imem_req=0 and id_valid=0 until reset.
